// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer with a one-word holding buffer so that
// back-to-back words stream out with no idle cycle between them.
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             q,
  output logic             q_valid,
  output logic             q_last
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]       state, state_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] hold, hold_n;
  logic             hold_full, hold_full_n;
  logic             accept;
  logic             last_bit;
  logic [WIDTH-1:0] shifted;
  logic             out_bit_n;

  assign load_ready = !hold_full;
  assign accept     = load_valid && load_ready;
  assign last_bit   = (state == SHIFT) && (cnt == LAST_IDX);
  assign shifted    = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};

  always_comb begin
    state_n     = state;
    shreg_n     = shreg;
    cnt_n       = cnt;
    hold_n      = hold;
    hold_full_n = hold_full;
    if (state == IDLE) begin
      if (accept) begin
        shreg_n = din;
        cnt_n   = '0;
        state_n = SHIFT;
      end
    end else if (last_bit) begin
      // A buffered word has priority; load_ready is low then, so no accept can collide.
      if (hold_full) begin
        shreg_n     = hold;
        cnt_n       = '0;
        hold_full_n = 1'b0;
      end else if (accept) begin
        shreg_n = din;
        cnt_n   = '0;
      end else begin
        shreg_n = '0;
        cnt_n   = '0;
        state_n = IDLE;
      end
    end else begin
      shreg_n = shifted;
      cnt_n   = cnt + 1'b1;
      if (accept) begin
        hold_n      = din;
        hold_full_n = 1'b1;
      end
    end
  end

  assign out_bit_n = MSB_FIRST ? shreg_n[WIDTH-1] : shreg_n[0];

  // Outputs are registered from the next-state values so nothing combinational reaches the pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shreg     <= '0;
      cnt       <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      q         <= 1'b0;
      q_valid   <= 1'b0;
      q_last    <= 1'b0;
    end else begin
      state     <= state_n;
      shreg     <= shreg_n;
      cnt       <= cnt_n;
      hold      <= hold_n;
      hold_full <= hold_full_n;
      q         <= (state_n == SHIFT) && out_bit_n;
      q_valid   <= (state_n == SHIFT);
      q_last    <= (state_n == SHIFT) && (cnt_n == LAST_IDX);
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: an MSB-first and an LSB-first instance
// driven by the same inputs, checked against hand-computed bit streams.
module tb_piso_serializer;

  logic       clk;
  logic       rst_n;
  logic [3:0] din;
  logic       load_valid;
  logic       load_ready, q, q_valid, q_last;
  logic       l_load_ready, l_q, l_q_valid, l_q_last;

  int vectors;
  int miscompares;

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst_n(rst_n), .din(din), .load_valid(load_valid),
    .load_ready(load_ready), .q(q), .q_valid(q_valid), .q_last(q_last)
  );

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .din(din), .load_valid(load_valid),
    .load_ready(l_load_ready), .q(l_q), .q_valid(l_q_valid), .q_last(l_q_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_bit(input string tag, input logic exp_q, input logic exp_last);
    chk({tag, ".q"}, q, exp_q);
    chk({tag, ".q_valid"}, q_valid, 1'b1);
    chk({tag, ".q_last"}, q_last, exp_last);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".q"}, q, 1'b0);
    chk({tag, ".q_valid"}, q_valid, 1'b0);
    chk({tag, ".q_last"}, q_last, 1'b0);
    chk({tag, ".load_ready"}, load_ready, 1'b1);
  endtask

  initial begin
    logic [7:0] exp8;
    logic [3:0] lsb_exp;
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    din         = 4'b0000;
    load_valid  = 1'b0;

    // Reset values, then an idle stretch with no offered word
    #1;
    chk_idle("reset");
    chk("reset.lsb_valid", l_q_valid, 1'b0);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk_idle("idle");
    end

    // Single word 1011: MSB-first 1,0,1,1 and LSB-first 1,1,0,1
    din = 4'b1011; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    lsb_exp = 4'b1011;
    for (int i = 0; i < 4; i++) begin
      chk_bit("single", din[3-i], i == 3);
      chk("lsb.q", l_q, lsb_exp[i]);
      chk("lsb.q_valid", l_q_valid, 1'b1);
      chk("lsb.q_last", l_q_last, i == 3);
      step();
    end
    chk_idle("single_end");
    chk("lsb_end.q_valid", l_q_valid, 1'b0);

    // Back-to-back through the holding buffer: 1011 then 0110
    step();
    din = 4'b1011; load_valid = 1'b1;
    step();
    exp8 = 8'b1011_0110;
    for (int i = 0; i < 8; i++) begin
      chk_bit("b2b", exp8[7-i], (i == 3) || (i == 7));
      chk("b2b.load_ready", load_ready, !(i >= 1 && i <= 3));
      if (i == 0) begin
        din = 4'b0110; load_valid = 1'b1;
      end else begin
        load_valid = 1'b0;
      end
      step();
    end
    chk_idle("b2b_end");

    // Bypass: 0011 offered exactly at the last-bit edge of 1100
    step();
    din = 4'b1100; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    exp8 = 8'b1100_0011;
    for (int i = 0; i < 8; i++) begin
      chk_bit("bypass", exp8[7-i], (i == 3) || (i == 7));
      if (i == 3) begin
        din = 4'b0011; load_valid = 1'b1;
      end else begin
        load_valid = 1'b0;
      end
      step();
    end
    chk_idle("bypass_end");

    // Reset mid-word with 0101 waiting in the holding buffer
    step();
    din = 4'b1011; load_valid = 1'b1;
    step();
    chk_bit("mid.b0", 1'b1, 1'b0);
    din = 4'b0101; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    chk_bit("mid.b1", 1'b0, 1'b0);
    chk("mid.load_ready", load_ready, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk_idle("mid_reset");
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_idle("post_reset");
    end
    din = 4'b0101; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk_bit("fresh", din[3-i], i == 3);
      step();
    end
    chk_idle("fresh_end");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in serial-out serializer, the transmit-side counterpart to the team's `sipo` shift register. It accepts WIDTH-bit words over a valid/ready load handshake and shifts them out one bit per clock, flagging each valid bit and the last bit of each word. A one-word holding buffer allows back-to-back words to stream with no idle cycle between them. It sits in front of any `sipo` instance as the serial-link driver.

## Interface

Parameters:

- WIDTH, 4, word width in bits; legal range 2..32.
- MSB_FIRST, 1, bit order. 1 shifts bit WIDTH-1 first; 0 shifts bit 0 first.

Ports:

- clk  input  1  rising-edge clock, the single clock of the block.
- rst_n  input  1  reset, asynchronous assert, active-low.
- din  input  WIDTH  parallel word; sampled only when the load handshake completes.
- load_valid  input  1  producer has a word on din.
- load_ready  output  1  block can accept a word this cycle; equals !hold_full; registered-state derived.
- q  output  1  serial data bit, registered.
- q_valid  output  1  q carries a valid bit this cycle, registered.
- q_last  output  1  q is the final bit of the current word; only ever high with q_valid.

## Operation

- Handshake: a word is accepted at a rising clk edge where load_valid && load_ready.
  - load_valid may drop or change din freely while load_ready is low; no word is lost or duplicated.
- State:
  - shreg[WIDTH-1:0]: the active word.
  - cnt[$clog2(WIDTH)-1:0]: index of the bit currently on q.
  - hold[WIDTH-1:0] and hold_full: the one-word buffer.
  - FSM: IDLE and SHIFT.
- IDLE (q_valid=0):
  - An accepted word loads directly into shreg, with cnt=0, and the FSM moves to SHIFT.
  - hold stays empty.
- SHIFT (q_valid=1):
  - q = shreg[WIDTH-1] if MSB_FIRST, else shreg[0].
  - Each edge shifts shreg by one toward the output end and increments cnt.
  - q_last = (cnt == WIDTH-1).
- Accept during SHIFT, not on the last bit: the word goes to hold and hold_full is set.
- End of word, at the edge where cnt == WIDTH-1:
  - If hold_full: shreg <= hold, cnt <= 0, hold_full <= 0, stay in SHIFT. No gap cycle.
  - Else, if a word is accepted at this same edge: it bypasses hold straight into shreg, cnt <= 0, stay in SHIFT. No gap cycle.
  - Else: go to IDLE, q_valid <= 0, q <= 0.
- Simultaneous events when hold_full=1 on the last bit: hold moves to shreg and load_ready is low, so no new accept is possible at that edge.
- Idle output: q is driven 0 whenever q_valid=0.
- Reset (rst_n low, at any time, including mid-word):
  - Immediately clears shreg, hold, hold_full, cnt, q, q_valid and q_last to 0.
  - FSM returns to IDLE and load_ready=1.
  - Partially sent and buffered words are discarded.
  - The first accept can occur at the first rising edge after rst_n deasserts.

## Timing

- Latency: word accepted at edge k → bit 0 of the word on q, with q_valid=1, in the cycle after edge k.
- Duration: each word occupies exactly WIDTH consecutive q_valid cycles; q_last is high in the WIDTH-th.
- Throughput: one word per WIDTH cycles sustained, provided the producer offers the next word no later than the last-bit edge.
- Backpressure: load_ready drops the cycle after hold fills and rises the cycle after hold drains into shreg.
- Outputs: all outputs come from flops; there is no combinational path from inputs to outputs.

## Test plan

1. Reset values: rst_n=0 → q=0, q_valid=0, q_last=0, load_ready=1. After release, load_ready=1 is held with load_valid=0 for 10 cycles → q_valid stays 0.
2. Single word, WIDTH=4, MSB_FIRST=1: din=4'b1011 accepted → q sequence 1,0,1,1 on 4 consecutive cycles with q_valid=1. q_last is high only on the 4th. The next cycle shows q_valid=0.
3. Back-to-back with buffering: load_valid held high with 4'b1011 then 4'b0110 → 8 consecutive valid bits 1,0,1,1,0,1,1,0. q_last is high on bits 4 and 8. load_ready is low between the second accept and the first word's last-bit edge.
4. Bypass at the boundary: hold empty, a word 4'b0011 is offered exactly at the last-bit edge of 4'b1100 → stream 1,1,0,0,0,0,1,1 with no q_valid gap.
5. LSB-first: MSB_FIRST=0, din=4'b1011 → q sequence 1,1,0,1.
6. Reset mid-word: assert rst_n low after the 2nd bit of 4'b1011, with 4'b0101 in hold → q_valid and hold_full clear immediately. After release, a fresh 4'b0101 is sent correctly and no stale bits appear.
